// File: rtl/acc12_pkg.sv
// Shared definitions for the 12-bit burst accumulator: widths, FSM states, saturation constant.
package acc12_pkg;

  localparam int unsigned ACC_WIDTH   = 12;
  localparam int unsigned ACC_COUNT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  localparam logic [ACC_WIDTH-1:0] SAT_VALUE = '1;

endpackage

// File: rtl/acc12_add_core.sv
// Combinational WIDTH-bit carry adder with carry-in tied low; carry-out from the top bit.
module acc12_add_core
  import acc12_pkg::*;
#(
  parameter int unsigned WIDTH = ACC_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  always_comb begin
    {cout, sum} = {1'b0, a} + {1'b0, b};
  end

endmodule

// File: rtl/acc12_burst_accumulator.sv
// Sums a burst of LEN samples into a registered total with sticky carry flag, held until taken.
// Optional macro ACC_SATURATE_EN: clamp the accumulator to all ones on any carry-out.
module acc12_burst_accumulator
  import acc12_pkg::*;
#(
  parameter int unsigned WIDTH   = ACC_WIDTH,
  parameter int unsigned COUNT_W = ACC_COUNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [COUNT_W-1:0] len,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_sum,
  output logic               out_ovf,
  output logic               busy
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic               ovf_q, ovf_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0]   add_sum;
  logic               add_cout;
  logic [WIDTH-1:0]   acc_next;

  acc12_add_core #(.WIDTH(WIDTH)) u_add (
    .a    (acc_q),
    .b    (in_data),
    .sum  (add_sum),
    .cout (add_cout)
  );

`ifdef ACC_SATURATE_EN
  // Once at all ones, any non-zero sample carries again, so the clamp holds for the burst.
  assign acc_next = add_cout ? SAT_VALUE : add_sum;
`else
  assign acc_next = add_sum;
`endif

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);
  assign busy      = (state_q != IDLE);
  assign out_sum   = acc_q;
  assign out_ovf   = ovf_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = len;
          state_d = (len != '0) ? ACCUM : HOLD;
        end
      end
      ACCUM: begin
        if (in_valid) begin
          acc_d = acc_next;
          ovf_d = ovf_q | add_cout;
          cnt_d = cnt_q - COUNT_W'(1);
          if (cnt_q == COUNT_W'(1)) state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_acc12_burst_accumulator.sv
// Randomized self-checking bench for acc12_burst_accumulator against a running-sum reference model.
module tb_acc12_burst_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  len;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_sum;
  logic        out_ovf;
  logic        busy;

  int vectors = 0;
  int errors  = 0;
  logic [11:0] samples[$];

  acc12_burst_accumulator #(.WIDTH(12), .COUNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: integer running total; any total above 4095 is a carry event.
  task automatic model(output logic [11:0] s, output logic o);
    int unsigned total;
    total = 0;
    o = 1'b0;
    foreach (samples[i]) begin
      total = total + int'(samples[i]);
      if (total > 4095) begin
        o = 1'b1;
`ifdef ACC_SATURATE_EN
        total = 4095;
`else
        total = total - 4096;
`endif
      end
    end
    s = total[11:0];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_burst(input int n, input int max_gap, input int stall,
                          output logic [11:0] s, output logic o, output bit lat_ok,
                          output bit stable_ok, output bit ready_in_hold, output bit tmo);
    int budget;
    lat_ok = 1'b0; stable_ok = 1'b1; ready_in_hold = 1'b0; tmo = 1'b0;
    start = 1'b1;
    len = n[7:0];
    tick();
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, max_gap)) begin
        in_valid = 1'b0;
        tick();
      end
      in_valid = 1'b1;
      in_data  = samples[i];
      budget = 0;
      while (!in_ready && budget < 50) begin
        tick();
        budget++;
      end
      if (!in_ready) tmo = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    in_data  = $urandom_range(0, 4095);
    lat_ok = out_valid;
    s = out_sum;
    o = out_ovf;
    if (in_ready) ready_in_hold = 1'b1;
    for (int c = 0; c < stall; c++) begin
      tick();
      if (!out_valid || out_sum !== s || out_ovf !== o) stable_ok = 1'b0;
      if (in_ready) ready_in_hold = 1'b1;
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    vectors++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    vectors++; if (out_sum !== 12'h000) begin errors++; $display("FAIL reset_out_sum got %h want 000", out_sum); end
    vectors++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL reset_out_ovf got %b want 0", out_ovf); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [11:0] s; logic o; bit lat, stb, rdy, tmo;
    samples = '{12'h100, 12'h200, 12'h00F};
    do_burst(3, 0, 0, s, o, lat, stb, rdy, tmo);
    vectors++; if (tmo) begin errors++; $display("FAIL basic_timeout got 1 want 0"); end
    vectors++; if (!lat) begin errors++; $display("FAIL basic_latency out_valid got 0 want 1"); end
    vectors++; if (s !== 12'h30F) begin errors++; $display("FAIL basic_sum got %h want 30f", s); end
    vectors++; if (o !== 1'b0) begin errors++; $display("FAIL basic_ovf got %b want 0", o); end
    vectors++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL basic_idle busy=%b out_valid=%b want 0,0", busy, out_valid); end
  endtask

  task automatic test_overflow();
    logic [11:0] s; logic o; bit lat, stb, rdy, tmo;
    logic [11:0] want;
`ifdef ACC_SATURATE_EN
    want = 12'hFFF;
`else
    want = 12'h001;
`endif
    samples = '{12'hFFF, 12'h002};
    do_burst(2, 0, 0, s, o, lat, stb, rdy, tmo);
    vectors++; if (!lat || tmo) begin errors++; $display("FAIL ovf_latency lat=%b tmo=%b want 1,0", lat, tmo); end
    vectors++; if (s !== want) begin errors++; $display("FAIL ovf_sum got %h want %h", s, want); end
    vectors++; if (o !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", o); end
  endtask

  task automatic test_stall();
    logic [11:0] s, es; logic o, eo; bit lat, stb, rdy, tmo;
    samples.delete();
    for (int i = 0; i < 4; i++) samples.push_back(12'($urandom_range(0, 4095)));
    model(es, eo);
    do_burst(4, 3, 5, s, o, lat, stb, rdy, tmo);
    vectors++; if (!lat || tmo) begin errors++; $display("FAIL stall_latency lat=%b tmo=%b want 1,0", lat, tmo); end
    vectors++; if (s !== es) begin errors++; $display("FAIL stall_sum got %h want %h", s, es); end
    vectors++; if (o !== eo) begin errors++; $display("FAIL stall_ovf got %b want %b", o, eo); end
    vectors++; if (!stb) begin errors++; $display("FAIL stall_stable got 0 want 1"); end
    vectors++; if (rdy) begin errors++; $display("FAIL stall_in_ready_in_hold got 1 want 0"); end
  endtask

  task automatic test_len0();
    logic [11:0] s; logic o; bit lat, stb, rdy, tmo;
    samples.delete();
    do_burst(0, 0, 2, s, o, lat, stb, rdy, tmo);
    vectors++; if (!lat) begin errors++; $display("FAIL len0_latency out_valid got 0 want 1"); end
    vectors++; if (s !== 12'h000) begin errors++; $display("FAIL len0_sum got %h want 000", s); end
    vectors++; if (o !== 1'b0) begin errors++; $display("FAIL len0_ovf got %b want 0", o); end
    vectors++; if (rdy) begin errors++; $display("FAIL len0_in_ready got 1 want 0"); end
  endtask

  task automatic test_rst_abort();
    logic [11:0] s; logic o; bit lat, stb, rdy, tmo;
    start = 1'b1; len = 8'd3;
    tick();
    start = 1'b0; in_valid = 1'b1; in_data = 12'h111;
    tick();
    in_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_out_valid got %b want 0", out_valid); end
    vectors++; if (busy !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL abort_idle busy=%b in_ready=%b want 0,0", busy, in_ready); end
    vectors++; if (out_sum !== 12'h000) begin errors++; $display("FAIL abort_sum_cleared got %h want 000", out_sum); end
    samples = '{12'h0AB};
    do_burst(1, 0, 0, s, o, lat, stb, rdy, tmo);
    vectors++; if (!lat || tmo) begin errors++; $display("FAIL abort_fresh_latency lat=%b tmo=%b want 1,0", lat, tmo); end
    vectors++; if (s !== 12'h0AB || o !== 1'b0) begin errors++; $display("FAIL abort_fresh_result got %h/%b want 0ab/0", s, o); end
  endtask

  task automatic test_ignore_start();
    start = 1'b1; len = 8'd2;
    tick();
    len = 8'd5; in_valid = 1'b1; in_data = 12'h010;
    tick();
    in_data = 12'h020;
    tick();
    in_valid = 1'b0;
    vectors++; if (out_valid !== 1'b1 || out_sum !== 12'h030) begin errors++; $display("FAIL ignore_accum got valid=%b sum=%h want 1/030", out_valid, out_sum); end
    out_ready = 1'b1;
    tick();
    start = 1'b0; out_ready = 1'b0;
    vectors++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL ignore_hold busy=%b out_valid=%b want 0,0", busy, out_valid); end
    tick();
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore_stays_idle busy got %b want 0", busy); end
  endtask

  task automatic test_random();
    logic [11:0] s, es; logic o, eo; bit lat, stb, rdy, tmo;
    int n;
    for (int b = 0; b < 25; b++) begin
      n = $urandom_range(1, 12);
      samples.delete();
      for (int i = 0; i < n; i++)
        samples.push_back(($urandom_range(0, 3) == 0) ? 12'($urandom_range(3500, 4095))
                                                      : 12'($urandom_range(0, 600)));
      model(es, eo);
      do_burst(n, 2, $urandom_range(0, 3), s, o, lat, stb, rdy, tmo);
      vectors++; if (!lat || tmo || !stb) begin errors++; $display("FAIL rand%0d_handshake lat=%b tmo=%b stable=%b want 1,0,1", b, lat, tmo, stb); end
      vectors++; if (s !== es || o !== eo) begin errors++; $display("FAIL rand%0d_result got %h/%b want %h/%b", b, s, o, es, eo); end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    test_reset();
    test_basic();
    test_overflow();
    test_stall();
    test_len0();
    test_rst_abort();
    test_ignore_start();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
